mem_bank_arbiter: RTL and testbench

- Shares the four-segment unified memory (banks 0..3, one port per bank) among NREQ pipeline requesters, e.g. fetch, load/store and debug.
- Each requester targets one bank per cycle.
- A round-robin arbiter per bank picks one winner per cycle and drives that bank's slice of the memory address, write-data and write-enable buses.
- Memory read is combinational. This block registers the read data and returns it one cycle after grant.

---
 rtl/mem_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 50 +++++
 rtl/mem_bank_arbiter.sv | 117 +++++++++++
 tb/tb_mem_bank_arbiter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared constants for the four-bank unified memory: bank ids, depths and data widths.
package mem_pkg;

  localparam int unsigned NBANKS = 4;

  localparam int unsigned BANK_DEPTH [NBANKS] = '{1024, 32, 1024, 512};

  localparam logic [1:0] BANK_IMEM = 2'd0;
  localparam logic [1:0] BANK_REG  = 2'd1;
  localparam logic [1:0] BANK_TAG  = 2'd2;
  localparam logic [1:0] BANK_DMEM = 2'd3;

  localparam int unsigned TAG_DW = 5;

  // Per-bank stored data width; only the tag bank is narrower than the bus.
  function automatic int unsigned bank_dw(input int unsigned bank, input int unsigned width);
    return (bank == 32'(BANK_TAG)) ? TAG_DW : width;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter for one bank: first candidate at or after the pointer wins.
module rr_arbiter #(
  parameter int unsigned NREQ = 3,
  localparam int unsigned PW = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] cand_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [PW-1:0]   ptr_o
);

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] win;
  logic          found;

  always_comb begin
    found = 1'b0;
    win   = '0;
    // Pass one covers [ptr, NREQ-1], pass two wraps to [0, ptr-1].
    for (int i = 0; i < NREQ; i++) begin
      if (!found && cand_i[i] && (PW'(i) >= ptr_q)) begin
        found = 1'b1;
        win   = PW'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!found && cand_i[i]) begin
        found = 1'b1;
        win   = PW'(i);
      end
    end
    if (!rst_n) found = 1'b0;

    gnt_o = '0;
    ptr_d = ptr_q;
    if (found) begin
      gnt_o[win] = 1'b1;
      ptr_d      = (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/mem_bank_arbiter.sv
// Shares four single-port memory banks among NREQ requesters; one round-robin
// arbiter per bank, range check, and a registered one-cycle read response.
module mem_bank_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned WIDTH = 36,
  parameter int unsigned NREQ  = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req,
  input  logic [2*NREQ-1:0]       req_bank,
  input  logic [NREQ-1:0]         req_we,
  input  logic [WIDTH*NREQ-1:0]   req_addr,
  input  logic [WIDTH*NREQ-1:0]   req_wdata,
  output logic [NREQ-1:0]         gnt,
  output logic [NREQ-1:0]         rvalid,
  output logic [WIDTH*NREQ-1:0]   rdata,
  output logic [NREQ-1:0]         rerr,
  output logic [NBANKS-1:0]       mem_we,
  output logic [WIDTH*NBANKS-1:0] mem_a,
  output logic [WIDTH*NBANKS-1:0] mem_wd,
  input  logic [WIDTH*NBANKS-1:0] mem_rd
);

  localparam int unsigned PW = $clog2(NREQ);

  function automatic logic [WIDTH-1:0] dw_mask(input int unsigned dw);
    logic [WIDTH-1:0] m;
    m = '0;
    for (int k = 0; k < WIDTH; k++) begin
      if (k < dw) m[k] = 1'b1;
    end
    return m;
  endfunction

  logic [NBANKS-1:0][NREQ-1:0]  cand;
  logic [NBANKS-1:0][NREQ-1:0]  gnt_b;
  logic [NBANKS-1:0][PW-1:0]    bank_ptr;
  logic [NBANKS-1:0][WIDTH-1:0] bank_rd;
  logic [NREQ-1:0]              req_in_range;

  logic [NREQ-1:0]       rvalid_q, rvalid_d;
  logic [NREQ-1:0]       rerr_q, rerr_d;
  logic [WIDTH*NREQ-1:0] rdata_q, rdata_d;

  for (genvar b = 0; b < NBANKS; b++) begin : g_bank
    rr_arbiter #(
      .NREQ(NREQ)
    ) u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .cand_i(cand[b]),
      .gnt_o (gnt_b[b]),
      .ptr_o (bank_ptr[b])
    );

    assign bank_rd[b] = mem_rd[WIDTH*b +: WIDTH] & dw_mask(bank_dw(b, WIDTH));

    ptr_in_range_a: assert property (@(posedge clk) disable iff (!rst_n)
      32'(bank_ptr[b]) < NREQ);
  end

  always_comb begin
    cand         = '0;
    gnt          = '0;
    mem_we       = '0;
    mem_a        = '0;
    mem_wd       = '0;
    req_in_range = '0;

    for (int i = 0; i < NREQ; i++) begin
      req_in_range[i] = req_addr[WIDTH*i +: WIDTH] < WIDTH'(BANK_DEPTH[req_bank[2*i +: 2]]);
      for (int b = 0; b < NBANKS; b++) begin
        cand[b][i] = req[i] && (req_bank[2*i +: 2] == 2'(b));
      end
    end

    // Grants are one-hot per bank, so OR-muxing selects the winner's fields.
    for (int b = 0; b < NBANKS; b++) begin
      gnt       = gnt | gnt_b[b];
      mem_we[b] = |(gnt_b[b] & req_we & req_in_range);
      for (int i = 0; i < NREQ; i++) begin
        if (gnt_b[b][i]) begin
          mem_a[WIDTH*b +: WIDTH]  = mem_a[WIDTH*b +: WIDTH]  | req_addr[WIDTH*i +: WIDTH];
          mem_wd[WIDTH*b +: WIDTH] = mem_wd[WIDTH*b +: WIDTH] | req_wdata[WIDTH*i +: WIDTH];
        end
      end
    end

    rvalid_d = gnt;
    rerr_d   = gnt & ~req_in_range;
    rdata_d  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i] && req_in_range[i]) begin
        rdata_d[WIDTH*i +: WIDTH] = bank_rd[req_bank[2*i +: 2]];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q <= '0;
      rerr_q   <= '0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= rvalid_d;
      rerr_q   <= rerr_d;
      rdata_q  <= rdata_d;
    end
  end

  assign rvalid = rvalid_q;
  assign rerr   = rerr_q;
  assign rdata  = rdata_q;

endmodule

// File: tb/tb_mem_bank_arbiter.sv
// Directed bench for mem_bank_arbiter with a behavioural four-bank memory model.
module tb_mem_bank_arbiter;

  localparam int W = 36;
  localparam int N = 3;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [2*N-1:0] req_bank;
  logic [N-1:0]   req_we;
  logic [W*N-1:0] req_addr;
  logic [W*N-1:0] req_wdata;
  logic [N-1:0]   gnt;
  logic [N-1:0]   rvalid;
  logic [W*N-1:0] rdata;
  logic [N-1:0]   rerr;
  logic [3:0]     mem_we;
  logic [W*4-1:0] mem_a;
  logic [W*4-1:0] mem_wd;
  logic [W*4-1:0] mem_rd;

  logic [W-1:0] mem [4][1024];

  int total = 0;
  int bad   = 0;

  mem_bank_arbiter #(
    .WIDTH(W),
    .NREQ (N)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .req_bank (req_bank),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .gnt      (gnt),
    .rvalid   (rvalid),
    .rdata    (rdata),
    .rerr     (rerr),
    .mem_we   (mem_we),
    .mem_a    (mem_a),
    .mem_wd   (mem_wd),
    .mem_rd   (mem_rd)
  );

  always #5 clk = ~clk;

  // Tag bank stores 5 bits; its upper read bits float high so missing masking shows.
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (mem_we[b]) begin
        if (b == 2) mem[b][mem_a[W*b +: 10]] <= {{(W-5){1'b0}}, mem_wd[W*b +: 5]};
        else        mem[b][mem_a[W*b +: 10]] <= mem_wd[W*b +: W];
      end
    end
  end

  for (genvar b = 0; b < 4; b++) begin : g_rd
    assign mem_rd[W*b +: W] = (mem_a[W*b +: W] < 1024) ?
        (mem[b][mem_a[W*b +: 10]] | ((b == 2) ? {{(W-5){1'b1}}, 5'b0} : {W{1'b0}})) : {W{1'b0}};
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic we, input logic [1:0] bank,
                         input logic [W-1:0] addr, input logic [W-1:0] data);
    req[i]              = 1'b1;
    req_we[i]           = we;
    req_bank[2*i +: 2]  = bank;
    req_addr[W*i +: W]  = addr;
    req_wdata[W*i +: W] = data;
  endtask

  task automatic clear_req();
    req       = '0;
    req_we    = '0;
    req_bank  = '0;
    req_addr  = '0;
    req_wdata = '0;
  endtask

  initial begin
    for (int b = 0; b < 4; b++) begin
      for (int a = 0; a < 1024; a++) mem[b][a] = '0;
    end
    for (int i = 0; i < 3; i++) mem[0][i] = 36'hA0000_0000 + W'(i);
    mem[3][7]  = 36'hABCDE0123;
    mem[1][0]  = 36'h000000055;
    mem[1][32] = 36'h00000DEAD;

    // Reset hold with all requesters asserting writes.
    rst_n = 1'b0;
    clear_req();
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 2'd0, W'(i), '1);
    #3;
    check("rst_gnt", gnt, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_rerr", rerr, 0);
    check("rst_rdata", rdata[W-1:0], 0);
    tick();
    tick();
    check("rst_gnt_after_edges", gnt, 0);
    clear_req();
    rst_n = 1'b1;
    #1;
    set_req(0, 1'b0, 2'd3, 0, 0);
    #1;
    check("first_gnt", gnt, 3'b001);
    tick();
    check("first_rvalid", rvalid, 3'b001);
    check("first_rerr", rerr, 0);
    clear_req();

    // Contention on bank 0: round-robin 0,1,2,0.
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 2'd0, W'(i), 0);
    #1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("rr_gnt%0d", k), gnt, 3'b001 << (k % 3));
      tick();
      check($sformatf("rr_rvalid%0d", k), rvalid, 3'b001 << (k % 3));
      check($sformatf("rr_rdata%0d", k), rdata[W*(k % 3) +: W], 36'hA0000_0000 + (k % 3));
    end
    clear_req();
    #1;
    check("rr_gnt_idle", gnt, 0);
    tick();
    check("rr_rvalid_idle", rvalid, 0);

    // Parallel banks: write bank 0 and read bank 3 together.
    set_req(0, 1'b1, 2'd0, 5, 36'h123456789);
    set_req(1, 1'b0, 2'd3, 7, 0);
    #1;
    check("par_gnt", gnt, 3'b011);
    check("par_mem_we", mem_we, 4'b0001);
    check("par_mem_a0", mem_a[W-1:0], 5);
    check("par_mem_wd0", mem_wd[W-1:0], 36'h123456789);
    check("par_mem_a3", mem_a[W*3 +: W], 7);
    check("par_mem_a1_idle", mem_a[W*1 +: W], 0);
    tick();
    check("par_rvalid", rvalid, 3'b011);
    check("par_rdata0_prewrite", rdata[W-1:0], 0);
    check("par_rdata1", rdata[W +: W], 36'hABCDE0123);
    clear_req();
    set_req(0, 1'b0, 2'd0, 5, 0);
    #1;
    check("rb_gnt", gnt, 3'b001);
    tick();
    check("rb_rdata0", rdata[W-1:0], 36'h123456789);
    clear_req();

    // Out-of-range write to bank 1.
    set_req(2, 1'b1, 2'd1, 32, 36'h777);
    #1;
    check("oor_gnt", gnt, 3'b100);
    check("oor_mem_we", mem_we, 0);
    tick();
    check("oor_rvalid", rvalid, 3'b100);
    check("oor_rerr", rerr, 3'b100);
    check("oor_rdata", rdata[W*2 +: W], 0);
    check("oor_mem32", mem[1][32], 36'h00000DEAD);
    clear_req();
    set_req(2, 1'b0, 2'd1, 0, 0);
    tick();
    check("oor_rd_rerr", rerr, 0);
    check("oor_rd_rdata", rdata[W*2 +: W], 36'h55);
    clear_req();

    // Narrow tag bank: five stored bits, zero-extended on read.
    set_req(1, 1'b1, 2'd2, 10, 36'hFFFFFFFFF);
    #1;
    check("tag_mem_we", mem_we, 4'b0100);
    check("tag_mem_wd", mem_wd[W*2 +: W], 36'hFFFFFFFFF);
    tick();
    clear_req();
    set_req(1, 1'b0, 2'd2, 10, 0);
    tick();
    check("tag_rvalid", rvalid, 3'b010);
    check("tag_rdata", rdata[W +: W], 36'h00000001F);
    clear_req();

    // Reset one cycle after a grant: response clears, pointers restart at 0.
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 2'd1, W'(i), 0);
    #1;
    check("mid_gnt", gnt, 3'b001);
    tick();
    check("mid_rvalid", rvalid, 3'b001);
    check("mid_gnt_next", gnt, 3'b010);
    rst_n = 1'b0;
    #1;
    check("mid_rst_rvalid", rvalid, 0);
    check("mid_rst_gnt", gnt, 0);
    check("mid_rst_rdata", rdata[W-1:0], 0);
    #1;
    rst_n = 1'b1;
    #1;
    check("mid_tie_gnt", gnt, 3'b001);
    tick();
    check("mid_tie_rvalid", rvalid, 3'b001);
    clear_req();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
